// File: rtl/y_stream_packer.sv
// rtl/y_stream_packer.sv - packs per-cycle FP16 adder-tree sums into P-lane words behind a small FWFT FIFO
//
// Purpose:
//   Gathers one DW-bit element per valid_in pulse into a packet of up to P lanes.
//   A packet closes when lane P-1 is filled or when last_in arrives. Each closed
//   packet is pushed into an FD-deep first-word fall-through FIFO. The FIFO drains
//   through a valid/ready port. There is no backpressure toward the adder tree.
//   A packet that cannot enter a full FIFO is dropped, and the sticky overflow
//   flag is set. Data bits pass through unchanged.
//
// Ports:
//   clk         single clock
//   rst         synchronous active-high reset; clears all partial and queued data
//   valid_in    sum_in carries an element this cycle
//   sum_in      element bit pattern (DW bits)
//   last_in     closes the current packet with this element
//   out_valid   FIFO head packet available
//   out_ready   consumer takes the head packet when out_valid is also high
//   out_data    packed lanes; lane k at [(k+1)*DW-1 -: DW], lane 0 received first
//   out_count   valid lanes in the head packet, 1..P
//   out_last    head packet was closed by last_in
//   fifo_level  packets held, 0..FD
//   overflow    sticky: a packet was dropped because the FIFO was full

module y_stream_packer #(
    parameter int DW = 16,
    parameter int P  = 8,
    parameter int FD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DW-1:0]         sum_in,
    input  logic                  last_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [P*DW-1:0]       out_data,
    output logic [$clog2(P):0]    out_count,
    output logic                  out_last,
    output logic [$clog2(FD):0]   fifo_level,
    output logic                  overflow
);

    localparam int CW = $clog2(P);
    localparam int AW = $clog2(FD);

    // ---------------- pack stage ----------------
    logic [CW-1:0]   cnt;
    logic [P*DW-1:0] lanes;
    logic            commit;
    logic [P*DW-1:0] commit_word;
    logic [CW:0]     commit_count;

    always_comb begin
        commit       = valid_in && ((cnt == CW'(P - 1)) || last_in);
        commit_count = (CW + 1)'(cnt) + (CW + 1)'(1);
        // Held lanes plus the incoming element. Lanes above cnt are still zero
        // because lanes is cleared on every commit.
        commit_word  = lanes;
        for (int k = 0; k < P; k++) begin
            if (cnt == CW'(k)) begin
                commit_word[k*DW +: DW] = sum_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            lanes <= '0;
        end else if (valid_in) begin
            if (commit) begin
                cnt   <= '0;
                lanes <= '0;
            end else begin
                cnt   <= cnt + CW'(1);
                lanes <= commit_word;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [P*DW-1:0] mem_data  [FD];
    logic [CW:0]     mem_count [FD];
    logic            mem_last  [FD];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic            pop;
    logic            push;
    logic            drop;

    // The last popped head is kept so the outputs hold their last values while
    // the FIFO is empty. After reset these registers read zero.
    logic [P*DW-1:0] hold_data;
    logic [CW:0]     hold_count;
    logic            hold_last;

    always_comb begin
        pop  = (level != '0) && out_ready;
        // When the FIFO is full, a pop in the same cycle frees the slot. The new
        // word goes into the slot being vacated, which becomes the tail.
        push = commit && ((level != (AW + 1)'(FD)) || pop);
        drop = commit && !push;
    end

    // Storage has no reset. Entries are only visible through level and rd_ptr.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wr_ptr]  <= commit_word;
            mem_count[wr_ptr] <= commit_count;
            mem_last[wr_ptr]  <= last_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            hold_data  <= '0;
            hold_count <= '0;
            hold_last  <= 1'b0;
        end else begin
            // FD is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                hold_data  <= mem_data[rd_ptr];
                hold_count <= mem_count[rd_ptr];
                hold_last  <= mem_last[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid  = (level != '0);
        fifo_level = level;
        if (out_valid) begin
            out_data  = mem_data[rd_ptr];
            out_count = mem_count[rd_ptr];
            out_last  = mem_last[rd_ptr];
        end else begin
            out_data  = hold_data;
            out_count = hold_count;
            out_last  = hold_last;
        end
    end

endmodule

// File: tb/tb_y_stream_packer.sv
// tb/tb_y_stream_packer.sv - self-checking bench for y_stream_packer

module tb_y_stream_packer;

    localparam int DW = 16;
    localparam int P  = 8;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_in = 1'b0;
    logic [DW-1:0]   sum_in = '0;
    logic            last_in = 1'b0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [P*DW-1:0] out_data;
    logic [3:0]      out_count;
    logic            out_last;
    logic [2:0]      fifo_level;
    logic            overflow;

    y_stream_packer #(.DW(DW), .P(P), .FD(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .sum_in     (sum_in),
        .last_in    (last_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P*DW-1:0] data;
        int              count;
        logic            last;
    } pkt_t;

    pkt_t          mq[$];
    logic [DW-1:0] part[$];
    logic          movf = 1'b0;
    logic          started = 1'b0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] v1 [8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a list of queued packets and the elements of the open packet.
    always @(posedge clk) begin
        pkt_t pk;
        if (rst) begin
            part.delete();
            mq.delete();
            movf <= 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (valid_in) begin
                part.push_back(sum_in);
                if (part.size() == P || last_in) begin
                    pk.data  = '0;
                    for (int i = 0; i < part.size(); i++) pk.data[i*DW +: DW] = part[i];
                    pk.count = part.size();
                    pk.last  = last_in;
                    if (mq.size() < FD) mq.push_back(pk);
                    else movf <= 1'b1;
                    part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("out_valid", 256'(out_valid), 256'(mq.size() != 0));
            chk("fifo_level", 256'(fifo_level), 256'(mq.size()));
            chk("overflow", 256'(overflow), 256'(movf));
            if (mq.size() != 0 && out_valid) begin
                chk("out_data", 256'(out_data), 256'(mq[0].data));
                chk("out_count", 256'(out_count), 256'(mq[0].count));
                chk("out_last", 256'(out_last), 256'(mq[0].last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        valid_in = 1'b1;
        sum_in   = d;
        last_in  = l;
        tick();
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v1 = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
        repeat (2) tick();
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk("reset out_data", 256'(out_data), 256'(0));
        chk("reset out_count", 256'(out_count), 256'(0));
        chk("reset out_last", 256'(out_last), 256'(0));
        chk("reset level", 256'(fifo_level), 256'(0));

        // Full packet of P elements, back to back
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(v1[i], 1'b0);
        @(negedge clk);
        chk("p8 valid", 256'(out_valid), 256'(1));
        chk("p8 data", 256'(out_data), 256'(128'h4800_4700_4600_4500_4400_4200_4000_3C00));
        chk("p8 count", 256'(out_count), 256'(8));
        chk("p8 last", 256'(out_last), 256'(0));
        tick();
        @(negedge clk);
        chk("p8 drained", 256'(fifo_level), 256'(0));

        // Early close with last_in, followed by a new packet starting at lane 0
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b1);
        @(negedge clk);
        chk("early data", 256'(out_data), 256'(128'h3333_2222_1111));
        chk("early count", 256'(out_count), 256'(3));
        chk("early last", 256'(out_last), 256'(1));
        send(16'h5555, 1'b1);
        @(negedge clk);
        chk("restart data", 256'(out_data), 256'(128'h5555));
        chk("restart count", 256'(out_count), 256'(1));
        repeat (3) tick();

        // Backpressure: five packets into a four-deep FIFO
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++)
            for (int i = 0; i < 8; i++) send(16'h1000 * 16'(p + 1) + 16'(i), 1'b0);
        @(negedge clk);
        chk("ovf level", 256'(fifo_level), 256'(4));
        chk("ovf flag", 256'(overflow), 256'(1));
        chk("ovf head", 256'(out_data[15:0]), 256'(16'h1000));
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("ovf drained", 256'(fifo_level), 256'(0));
        chk("ovf sticky", 256'(overflow), 256'(1));

        // Full FIFO with a pop in the same cycle as a commit
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 8; i++) send(16'h2000 + 16'h0100 * 16'(p) + 16'(i), 1'b0);
        for (int i = 0; i < 7; i++) send(16'h6000 + 16'(i), 1'b0);
        out_ready = 1'b1;
        send(16'h6007, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("fullpop level", 256'(fifo_level), 256'(4));
        chk("fullpop ovf", 256'(overflow), 256'(0));
        chk("fullpop head", 256'(out_data[15:0]), 256'(16'h2100));
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("fullpop drained", 256'(fifo_level), 256'(0));

        // Reset in the middle of a packet
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h7000 + 16'(i), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(16'hA000 + 16'(i), 1'b0);
        @(negedge clk);
        chk("rstmid valid", 256'(out_valid), 256'(1));
        chk("rstmid count", 256'(out_count), 256'(8));
        chk("rstmid data", 256'(out_data), 256'(128'hA007_A006_A005_A004_A003_A002_A001_A000));
        repeat (3) tick();

        // Random bubbles between elements
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if (i == 7) begin
                @(negedge clk);
                chk("bubble pre valid", 256'(out_valid), 256'(0));
            end
            send(v1[i], 1'b0);
        end
        @(negedge clk);
        chk("bubble valid", 256'(out_valid), 256'(1));
        chk("bubble data", 256'(out_data), 256'(128'h4800_4700_4600_4500_4400_4200_4000_3C00));
        chk("bubble count", 256'(out_count), 256'(8));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
